// File: rtl/serial_logic8_pkg.sv
// Shared opcode constants and FSM state encoding for the bit-serial logic unit.
package serial_logic_pkg;

  localparam logic [1:0] OP_AND = 2'b00;
  localparam logic [1:0] OP_OR  = 2'b01;
  localparam logic [1:0] OP_XOR = 2'b10;
  localparam logic [1:0] OP_NOT = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/serial_logic8_if.sv
// Operand/result handshake bundle between a byte producer, the serial unit and a consumer.
interface serial_logic8_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [1:0]       op;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] f;
  logic             busy;

  modport master (
    output in_valid, a, b, op, out_ready,
    input  in_ready, out_valid, f, busy
  );

  modport slave (
    input  in_valid, a, b, op, out_ready,
    output in_ready, out_valid, f, busy
  );
endinterface

// File: rtl/serial_logic8_logic_bit.sv
// Single-bit gate cell: one of AND/OR/XOR/NOT-A chosen by op. B is unused for NOT.
module logic_bit
  import serial_logic_pkg::*;
(
  output logic       f,
  input  logic       a,
  input  logic       b,
  input  logic [1:0] op
);

  wire and_w;
  wire or_w;
  wire xor_w;
  wire not_w;

  and g_and (and_w, a, b);
  or  g_or  (or_w,  a, b);
  xor g_xor (xor_w, a, b);
  not g_not (not_w, a);

  always_comb begin
    f = 1'b0;
    case (op)
      OP_AND:  f = and_w;
      OP_OR:   f = or_w;
      OP_XOR:  f = xor_w;
      OP_NOT:  f = not_w;
      default: f = 1'b0;
    endcase
  end

endmodule

// File: rtl/serial_logic8.sv
// Bit-serial logic unit: captures two operands, evaluates them LSB first through one
// gate cell over WIDTH cycles, then holds the result until the consumer takes it.
module serial_logic8
  import serial_logic_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  serial_logic8_if.slave bus
);

  localparam int              CNT_W    = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_sh_q,  a_sh_d;
  logic [WIDTH-1:0] b_sh_q,  b_sh_d;
  logic [1:0]       op_q,    op_d;
  logic [WIDTH-1:0] r_sh_q,  r_sh_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;
  logic [WIDTH-1:0] f_q,     f_d;
  logic             cell_f;

  logic_bit u_bit (
    .f  (cell_f),
    .a  (a_sh_q[0]),
    .b  (b_sh_q[0]),
    .op (op_q)
  );

  always_comb begin
    state_d = state_q;
    a_sh_d  = a_sh_q;
    b_sh_d  = b_sh_q;
    op_d    = op_q;
    r_sh_d  = r_sh_q;
    cnt_d   = cnt_q;
    f_d     = f_q;

    case (state_q)
      S_IDLE: begin
        if (bus.in_valid) begin
          a_sh_d  = bus.a;
          b_sh_d  = bus.b;
          op_d    = bus.op;
          r_sh_d  = '0;
          cnt_d   = '0;
          state_d = S_SHIFT;
        end
      end

      S_SHIFT: begin
        a_sh_d = a_sh_q >> 1;
        b_sh_d = b_sh_q >> 1;
        // New bit enters at the MSB so the first (LSB) result bit ends up at bit 0.
        r_sh_d = {cell_f, r_sh_q[WIDTH-1:1]};
        cnt_d  = cnt_q + CNT_ONE;
        if (cnt_q == CNT_LAST) begin
          f_d     = {cell_f, r_sh_q[WIDTH-1:1]};
          state_d = S_DONE;
        end
      end

      S_DONE: begin
        if (bus.out_ready) begin
          state_d = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      op_q    <= '0;
      r_sh_q  <= '0;
      cnt_q   <= '0;
      f_q     <= '0;
    end else begin
      state_q <= state_d;
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      op_q    <= op_d;
      r_sh_q  <= r_sh_d;
      cnt_q   <= cnt_d;
      f_q     <= f_d;
    end
  end

  // Handshake flags are pure state decodes; in_ready never looks at out_ready.
  assign bus.in_ready  = (state_q == S_IDLE);
  assign bus.out_valid = (state_q == S_DONE);
  assign bus.busy      = (state_q == S_SHIFT) || (state_q == S_DONE);
  assign bus.f         = f_q;

endmodule

// File: tb/tb_serial_logic8.sv
// Directed bench for serial_logic8 with a transaction-level reference model and per-cycle compare.
module tb_serial_logic8;
  import serial_logic_pkg::*;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   checks   = 0;
  int   failures = 0;
  logic cmp_en   = 1'b0;
  int   dut_hs   = 0;

  serial_logic8_if #(.WIDTH(8)) bus ();

  serial_logic8 #(.WIDTH(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: whole-byte result, known to appear 8 edges after acceptance.
  typedef enum int {M_IDLE, M_BUSY, M_DONE} mph_t;
  mph_t       m_ph     = M_IDLE;
  logic [7:0] m_f      = 8'h00;
  logic [7:0] m_res    = 8'h00;
  int         m_left   = 0;
  int         cyc      = 0;
  int         acc_last = -100;
  int         acc_prev = -100;

  function automatic logic [7:0] ref_op(input logic [7:0] x, input logic [7:0] y,
                                        input logic [1:0] o);
    case (o)
      2'b00:   return x & y;
      2'b01:   return x | y;
      2'b10:   return x ^ y;
      default: return ~x;
    endcase
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_ph   <= M_IDLE;
      m_f    <= 8'h00;
      m_left <= 0;
    end else begin
      cyc <= cyc + 1;
      case (m_ph)
        M_IDLE: if (bus.in_valid) begin
          m_res    <= ref_op(bus.a, bus.b, bus.op);
          m_left   <= 8;
          m_ph     <= M_BUSY;
          acc_prev <= acc_last;
          acc_last <= cyc;
        end
        M_BUSY: begin
          m_left <= m_left - 1;
          if (m_left == 1) begin
            m_f  <= m_res;
            m_ph <= M_DONE;
          end
        end
        default: if (bus.out_ready) m_ph <= M_IDLE;
      endcase
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("cyc_in_ready",  {31'd0, bus.in_ready},  {31'd0, m_ph == M_IDLE});
      chk("cyc_out_valid", {31'd0, bus.out_valid}, {31'd0, m_ph == M_DONE});
      chk("cyc_busy",      {31'd0, bus.busy},      {31'd0, m_ph != M_IDLE});
      chk("cyc_f",         {24'd0, bus.f},         {24'd0, m_f});
      if (bus.out_valid && bus.out_ready) dut_hs++;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_out(input string name, input logic [7:0] exp);
    for (int i = 0; i < 40; i++) begin
      step();
      if (bus.out_valid) begin
        chk(name, {24'd0, bus.f}, {24'd0, exp});
        return;
      end
    end
    chk({name, "_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic run_op(input logic [7:0] av, input logic [7:0] bv, input logic [1:0] ov,
                        input logic [7:0] exp, input string name);
    bus.a = av; bus.b = bv; bus.op = ov; bus.in_valid = 1'b1;
    step();
    bus.in_valid = 1'b0;
    wait_out(name, exp);
    step();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int hs0;
    bus.in_valid = 1'b0; bus.a = '0; bus.b = '0; bus.op = '0; bus.out_ready = 1'b1;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    cmp_en = 1'b1;

    chk("rst_in_ready",  {31'd0, bus.in_ready},  32'd1);
    chk("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("rst_busy",      {31'd0, bus.busy},      32'd0);
    chk("rst_f",         {24'd0, bus.f},         32'h00);

    // AND with explicit latency
    bus.a = 8'hA5; bus.b = 8'h3C; bus.op = 2'b00; bus.in_valid = 1'b1;
    step();
    bus.in_valid = 1'b0;
    repeat (7) step();
    chk("and_not_yet", {31'd0, bus.out_valid}, 32'd0);
    step();
    chk("and_lat8", {31'd0, bus.out_valid}, 32'd1);
    chk("and_f",    {24'd0, bus.f},         32'h24);
    step();
    chk("and_ready_back", {31'd0, bus.in_ready}, 32'd1);

    // OR then XOR back-to-back with in_valid held high
    bus.a = 8'hA5; bus.b = 8'h3C; bus.op = 2'b01; bus.in_valid = 1'b1;
    step();
    bus.op = 2'b10;
    wait_out("or_f", 8'hBD);
    step();
    step();
    bus.in_valid = 1'b0;
    chk("b2b_interval", acc_last - acc_prev, 32'd10);
    wait_out("xor_f", 8'h99);
    step();

    // NOT ignores b
    run_op(8'hA5, 8'hFF, 2'b11, 8'h5A, "not_a5");
    run_op(8'h00, 8'h5C, 2'b11, 8'hFF, "not_00");
    run_op(8'hFF, 8'h00, 2'b11, 8'h00, "not_ff");

    // Backpressure
    bus.out_ready = 1'b0;
    bus.a = 8'h5A; bus.b = 8'h0F; bus.op = 2'b10; bus.in_valid = 1'b1;
    step();
    bus.in_valid = 1'b0;
    wait_out("bp_f", 8'h55);
    hs0 = dut_hs;
    for (int i = 0; i < 5; i++) begin
      bus.in_valid = 1'b1; bus.a = 8'(i * 37); bus.op = 2'b01;
      step();
      chk("bp_hold_valid", {31'd0, bus.out_valid}, 32'd1);
      chk("bp_hold_f",     {24'd0, bus.f},         32'h55);
      chk("bp_in_ready",   {31'd0, bus.in_ready},  32'd0);
    end
    bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    step();
    chk("bp_release_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("bp_release_ready", {31'd0, bus.in_ready},  32'd1);
    repeat (3) step();
    chk("bp_no_accept", {31'd0, bus.busy}, 32'd0);
    chk("bp_one_hs", dut_hs - hs0, 32'd1);

    // Operand changes during SHIFT have no effect
    bus.a = 8'hC3; bus.b = 8'h96; bus.op = 2'b00; bus.in_valid = 1'b1;
    step();
    bus.in_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      bus.a = 8'($urandom); bus.b = 8'($urandom); bus.op = 2'($urandom);
      step();
    end
    chk("stab_valid", {31'd0, bus.out_valid}, 32'd1);
    chk("stab_f",     {24'd0, bus.f},         32'h82);
    step();

    // Reset after the 4th shift edge
    bus.a = 8'hFF; bus.b = 8'h00; bus.op = 2'b01; bus.in_valid = 1'b1;
    step();
    bus.in_valid = 1'b0;
    repeat (4) step();
    rst_n = 1'b0;
    #1;
    chk("mid_rst_in_ready",  {31'd0, bus.in_ready},  32'd1);
    chk("mid_rst_busy",      {31'd0, bus.busy},      32'd0);
    chk("mid_rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("mid_rst_f",         {24'd0, bus.f},         32'h00);
    @(posedge clk);
    #1 rst_n = 1'b1;
    run_op(8'h0F, 8'hF0, 2'b10, 8'hFF, "post_rst_xor");

    repeat (2) step();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
